// File: rtl/rob_scoreboard.sv
// rob_scoreboard: in-order tracking buffer between dispatch and commit.
//
// Each dispatched instruction gets the tail entry as its transaction ID.
// Writeback ports mark entries done with a result and exception flag.
// Up to NR_COMMIT_PORTS completed entries retire per cycle, oldest first.
// Two lookup ports report whether a register has an in-flight producer
// and, if the youngest producer is done, its result.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   flush_i                  drop every in-flight entry
//   disp_*                   dispatch request, readiness, assigned ID
//   wb_*                     per-port writeback (flattened vectors)
//   commit_*                 per-port retire window starting at head
//   rs1_*/rs2_*              operand busy / forwarding lookup
//   full_o, empty_o, count_o occupancy
module rob_scoreboard #(
  parameter int NR_ENTRIES      = 8,
  parameter int NR_WB_PORTS     = 4,
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DATA_W          = 64,
  localparam int IDW            = $clog2(NR_ENTRIES)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              disp_valid_i,
  output logic                              disp_ready_o,
  input  logic [4:0]                        disp_rd_i,
  input  logic                              disp_we_i,
  output logic [IDW-1:0]                    disp_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]            wb_valid_i,
  input  logic [NR_WB_PORTS*IDW-1:0]        wb_trans_id_i,
  input  logic [NR_WB_PORTS*DATA_W-1:0]     wb_data_i,
  input  logic [NR_WB_PORTS-1:0]            wb_ex_i,
  output logic [NR_COMMIT_PORTS-1:0]        commit_valid_o,
  output logic [NR_COMMIT_PORTS*5-1:0]      commit_rd_o,
  output logic [NR_COMMIT_PORTS-1:0]        commit_we_o,
  output logic [NR_COMMIT_PORTS*DATA_W-1:0] commit_data_o,
  output logic [NR_COMMIT_PORTS-1:0]        commit_ex_o,
  input  logic [NR_COMMIT_PORTS-1:0]        commit_ack_i,
  input  logic [4:0]                        rs1_i,
  input  logic [4:0]                        rs2_i,
  output logic                              rs1_busy_o,
  output logic                              rs1_fwd_valid_o,
  output logic [DATA_W-1:0]                 rs1_fwd_data_o,
  output logic                              rs2_busy_o,
  output logic                              rs2_fwd_valid_o,
  output logic [DATA_W-1:0]                 rs2_fwd_data_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [IDW:0]                      count_o
);

  // Per-entry state
  logic [NR_ENTRIES-1:0] alloc_q, done_q, ex_q, we_q;
  logic [4:0]            rd_q   [NR_ENTRIES];
  logic [DATA_W-1:0]     data_q [NR_ENTRIES];

  logic [IDW-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDW:0]   count_q, count_d;

  logic                       disp_fire;
  logic [NR_COMMIT_PORTS-1:0] commit_valid, retire_k;
  logic [IDW:0]               retire_n;
  logic                       prev_ok, run;
  logic [IDW-1:0]             lk_e, lk1_idx, lk2_idx;
  logic                       lk1_hit, lk2_hit;

  // Pointer arithmetic wraps naturally in IDW bits (depth is a power of two).
  function automatic logic [IDW-1:0] ptr_add(input logic [IDW-1:0] base, input int off);
    return base + IDW'(off);
  endfunction

  assign full_o          = (count_q == (IDW+1)'(NR_ENTRIES));
  assign empty_o         = (count_q == '0);
  assign count_o         = count_q;
  assign disp_ready_o    = ~full_o;
  assign disp_trans_id_o = tail_q;
  assign disp_fire       = disp_valid_i & ~full_o;

  // Commit window and retire count.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    commit_valid  = '0;
    retire_k      = '0;
    retire_n      = '0;
    commit_rd_o   = '0;
    commit_we_o   = '0;
    commit_data_o = '0;
    commit_ex_o   = '0;
    prev_ok       = 1'b1;
    run           = 1'b1;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      commit_valid[k] = prev_ok & alloc_q[ptr_add(head_q, k)] & done_q[ptr_add(head_q, k)];
      // An excepting entry closes the window: it retires alone on port 0.
      prev_ok = commit_valid[k] & ~ex_q[ptr_add(head_q, k)];
      commit_rd_o[k*5 +: 5]           = rd_q[ptr_add(head_q, k)];
      commit_we_o[k]                  = we_q[ptr_add(head_q, k)];
      commit_data_o[k*DATA_W +: DATA_W] = data_q[ptr_add(head_q, k)];
      commit_ex_o[k]                  = ex_q[ptr_add(head_q, k)];
      // Only the leading run of valid & ack retires; later acks are ignored.
      run         = run & commit_valid[k] & commit_ack_i[k];
      retire_k[k] = run;
      if (run) retire_n = retire_n + (IDW+1)'(1);
    end
  end

  assign commit_valid_o = commit_valid;
  assign head_d         = head_q + retire_n[IDW-1:0];
  assign tail_d         = tail_q + IDW'(disp_fire);
  assign count_d        = count_q + (IDW+1)'(disp_fire) - retire_n;

  // Operand lookup: walk from head in age order, keep the last (youngest) hit.
  always_comb begin
    lk1_hit = 1'b0;
    lk2_hit = 1'b0;
    lk1_idx = '0;
    lk2_idx = '0;
    lk_e    = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      lk_e = ptr_add(head_q, i);
      if (alloc_q[lk_e] && we_q[lk_e] && rd_q[lk_e] == rs1_i && rs1_i != 5'd0) begin
        lk1_hit = 1'b1;
        lk1_idx = lk_e;
      end
      if (alloc_q[lk_e] && we_q[lk_e] && rd_q[lk_e] == rs2_i && rs2_i != 5'd0) begin
        lk2_hit = 1'b1;
        lk2_idx = lk_e;
      end
    end
  end

  // Data is cleared on dispatch, so a pending producer forwards zero.
  assign rs1_busy_o      = lk1_hit;
  assign rs1_fwd_valid_o = lk1_hit & done_q[lk1_idx];
  assign rs1_fwd_data_o  = lk1_hit ? data_q[lk1_idx] : '0;
  assign rs2_busy_o      = lk2_hit;
  assign rs2_fwd_valid_o = lk2_hit & done_q[lk2_idx];
  assign rs2_fwd_data_o  = lk2_hit ? data_q[lk2_idx] : '0;

  // NOTE: sequential state uses non-blocking assignments only, so later
  // writes in this block (highest writeback port, retire clear) win cleanly.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      // NOTE: only alloc and pointers are reset; the payload arrays are
      // qualified by alloc and rewritten on dispatch, so they need no reset.
      alloc_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (disp_fire) begin
        alloc_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        ex_q[tail_q]    <= 1'b0;
        we_q[tail_q]    <= disp_we_i;
        rd_q[tail_q]    <= disp_rd_i;
        data_q[tail_q]  <= '0;
      end
      // Ascending port order: the highest port hitting an ID wins.
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && alloc_q[wb_trans_id_i[p*IDW +: IDW]]) begin
          done_q[wb_trans_id_i[p*IDW +: IDW]] <= 1'b1;
          ex_q[wb_trans_id_i[p*IDW +: IDW]]   <= wb_ex_i[p];
          data_q[wb_trans_id_i[p*IDW +: IDW]] <= wb_data_i[p*DATA_W +: DATA_W];
        end
      end
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
        if (retire_k[k]) alloc_q[ptr_add(head_q, k)] <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rob_scoreboard.md
# rob_scoreboard

Parametrised in-order tracking buffer for the issue stage. It allocates one transaction ID per dispatched instruction, captures results from any number of writeback ports, and retires up to NR_COMMIT_PORTS completed instructions per cycle in program order. It also answers per-register busy/forwarding lookups for operand read. It sits between decode/dispatch and commit, generalising the single-port scoreboard to configurable depth, writeback width, commit width and data width, and adds a full flush.

## Interface
- NR_ENTRIES, 8, buffer depth; power of two, ≥2; IDW = $clog2(NR_ENTRIES)
- NR_WB_PORTS, 4, number of writeback ports
- NR_COMMIT_PORTS, 2, maximum retirements per cycle; 1..NR_ENTRIES
- DATA_W, 64, result width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all in-flight entries
- disp_valid_i  in  1  dispatch request
- disp_ready_o  out  1  entry available (= !full_o)
- disp_rd_i  in  5  destination register
- disp_we_i  in  1  instruction writes rd
- disp_trans_id_o  out  IDW  ID assigned to the current dispatch (tail pointer)
- wb_valid_i  in  NR_WB_PORTS  writeback valid per port
- wb_trans_id_i  in  NR_WB_PORTS×IDW  target entry per port
- wb_data_i  in  NR_WB_PORTS×DATA_W  result per port
- wb_ex_i  in  NR_WB_PORTS  exception flag per port
- commit_valid_o  out  NR_COMMIT_PORTS  entry head+k is ready to retire
- commit_rd_o / commit_we_o / commit_data_o / commit_ex_o  out  per port  5 / 1 / DATA_W / 1 fields of entry head+k
- commit_ack_i  in  NR_COMMIT_PORTS  retire acknowledgement
- rs1_i, rs2_i  in  5  lookup register addresses
- rsN_busy_o  out  1  an in-flight entry writes rsN
- rsN_fwd_valid_o  out  1  youngest such entry has its result
- rsN_fwd_data_o  out  DATA_W  that result
- full_o, empty_o  out  1  occupancy flags
- count_o  out  IDW+1  occupied entries

## Operation
- State per entry: alloc, done, ex, we, rd, data. Pointers head, tail (IDW bits, wrap modulo NR_ENTRIES), count (IDW+1 bits).
- Dispatch: fires when disp_valid_i && disp_ready_o. Entry[tail] gets alloc=1, done=0, ex=0, we, rd; tail++. disp_ready_o depends only on registered count, so a full buffer refuses dispatch even when a commit happens in the same cycle.
- Writeback: for each port with wb_valid_i and alloc[trans_id]=1, set done=1, data, ex. A writeback to an unallocated entry is ignored. If two ports hit the same ID in one cycle, the highest port index wins.
- Commit: commit_valid_o[k] = alloc && done for entry head+k, AND commit_valid_o[k-1], AND (k=0 or ex of head+k-1 = 0). An exception therefore retires alone on port 0. The effective retire count n is the length of the leading run of commit_valid_o & commit_ack_i; acks beyond the first gap are ignored. Retired entries get alloc=0, head += n.
- count_next = count + dispatch_fire − n. full_o = (count == NR_ENTRIES); empty_o = (count == 0).
- Lookup (combinational from registered state): search allocated entries with we=1 and rd == rsN, rsN ≠ 0, choosing the youngest in age order from head. busy = match found; fwd_valid = match.done; fwd_data = match.data, otherwise 0. rsN = 0 gives busy=0.
- Flush: next cycle all alloc=0, head=tail=count=0. Flush overrides dispatch, writeback and commit in the same cycle.

## Timing
- Reset values: disp_ready_o=1, disp_trans_id_o=0, commit_valid_o=0, busy/fwd_valid=0, fwd_data=0, full_o=0, empty_o=1, count_o=0. Reset mid-operation behaves exactly as flush.
- A dispatch at cycle t is visible to lookup and count at t+1.
- A writeback at cycle t produces commit_valid_o/fwd_valid at t+1 at the earliest. Writeback data is not bypassed within the same cycle.
- Minimum dispatch→commit_valid latency is 2 cycles (dispatch t, writeback t+1, commit_valid t+2).
- Pointer wrap: ID NR_ENTRIES−1 is followed by ID 0. Commit windows wrap across the boundary.

## Test plan
- Reset, then dispatch 8 instrs (rd=1..8) at NR_ENTRIES=8 -> IDs 0..7, full_o=1 and disp_ready_o=0 after the 8th, count_o=8.
- Write back ID1 then ID0 via ports 3 and 0 -> commit_valid_o=2'b00 after ID1 only, 2'b11 one cycle after ID0; ack 2'b11 -> head=2, count_o=6.
- Entry 0 with ex=1 and entry 1 done -> commit_valid_o=2'b01; after ack, entry 1 appears on port 0 the next cycle.
- Dispatch rd=5 twice (IDs 2,3), write back ID2 data 0xAA -> rs1_i=5 gives busy=1, fwd_valid=0; write back ID3 data 0xBB -> fwd_valid=1, fwd_data=0xBB.
- Fill, drain and refill across the wrap point (IDs 6,7,0,1 in flight), with commit_ack_i=2'b10 -> nothing retires, ack 2'b11 retires 6 and 7 in order.
- Flush asserted with dispatch and writeback in the same cycle -> next cycle empty_o=1, count_o=0, disp_trans_id_o=0, all busy outputs 0.
